seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH+1 edges accept-to-result (1 edge for divide-by-zero).
// Result is held in DONE under unbounded out_ready backpressure; in_ready is high only in IDLE.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divider,
  input  logic             flush,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             dividend_neg, divider_neg;
  logic [WIDTH-1:0] dividend_mag, divider_mag;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_next, quo_next;

  // quo_q starts as the dividend magnitude; its MSB feeds the remainder while quotient bits enter at the LSB
  always_comb begin
    dividend_neg = sign && dividend[WIDTH-1];
    divider_neg  = sign && divider[WIDTH-1];
    dividend_mag = dividend_neg ? -dividend : dividend;
    divider_mag  = divider_neg ? -divider : divider;
    rem_shift    = {rem_q, quo_q[WIDTH-1]};
    rem_ge       = rem_shift >= {1'b0, dvs_q};
    rem_next     = rem_ge ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
    quo_next     = {quo_q[WIDTH-2:0], rem_ge};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d     = divider_mag;
          quo_d     = dividend_mag;
          rem_d     = '0;
          neg_quo_d = dividend_neg ^ divider_neg;
          neg_rem_d = dividend_neg;
          if (divider == '0) begin
            state_d     = DONE;
            cnt_d       = '0;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
            dbz_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d     = DONE;
          quotient_d  = neg_quo_q ? -quo_next : quo_next;
          remainder_d = neg_rem_q ? -rem_next : rem_next;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over acceptance, completion and consumer handshake
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed and random divisions on 32- and 8-bit instances against an arithmetic model.
module tb_seq_divider;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, sign, flush, out_ready;
  logic [31:0] dividend, divider, quotient, remainder;
  logic        in_ready, out_valid, div_by_zero;

  logic        start8, sign8, flush8, out_ready8;
  logic [7:0]  dividend8, divider8, quotient8, remainder8;
  logic        in_ready8, out_valid8, div_by_zero8;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .dividend(dividend), .divider(divider), .flush(flush),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sign(sign8),
    .dividend(dividend8), .divider(divider8), .flush(flush8),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(div_by_zero8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Truncating division on w-bit operands; signed results wrap to w bits
  function automatic void model(input int w, input bit s, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r, output bit dz);
    logic [63:0] mask;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    if (b == 64'd0) begin
      q = mask; r = a; dz = 1'b1;
      return;
    end
    dz = 1'b0;
    if (s) begin
      sa = a[w-1] ? $signed(a | ~mask) : $signed(a);
      sb = b[w-1] ? $signed(b | ~mask) : $signed(b);
      q  = 64'(sa / sb) & mask;
      r  = 64'(sa % sb) & mask;
    end else begin
      q = (a / b) & mask;
      r = (a % b) & mask;
    end
  endfunction

  task automatic do_op32(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] eq, er;
    bit          ed;
    int          k, lat;
    logic [31:0] q0, r0;
    model(32, s, {32'd0, a}, {32'd0, b}, eq, er, ed);
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    start = 1'b1; sign = s; dividend = a; divider = b;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      dividend = $urandom; divider = $urandom; sign = 1'($urandom); start = 1'($urandom);
      @(negedge clk);
      k++;
      if (k == 3 && !out_valid) chk({tag, ".busy_in_ready"}, 64'(in_ready), 64'd0);
    end
    start = 1'b0;
    lat = k + 1;
    chk({tag, ".latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
    chk({tag, ".quotient"}, 64'(quotient), eq);
    chk({tag, ".remainder"}, 64'(remainder), er);
    chk({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(ed));
    q0 = quotient; r0 = remainder;
    for (int i = 0; i < hold; i++) begin
      start = 1'b1; dividend = $urandom; divider = $urandom;
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, ".hold_q"}, 64'(quotient), eq);
      chk({tag, ".hold_r"}, 64'(remainder), er);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".post_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".idle_q_kept"}, {r0, q0}, {remainder, quotient});
  endtask

  task automatic do_op8(input string tag, input bit s, input logic [7:0] a, input logic [7:0] b);
    logic [63:0] eq, er;
    bit          ed;
    int          k;
    model(8, s, {56'd0, a}, {56'd0, b}, eq, er, ed);
    chk({tag, ".in_ready"}, 64'(in_ready8), 64'd1);
    start8 = 1'b1; sign8 = s; dividend8 = a; divider8 = b;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!out_valid8 && k < 50) begin
      dividend8 = 8'($urandom); divider8 = 8'($urandom);
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, 64'(k + 1), (b == 8'd0) ? 64'd1 : 64'd9);
    chk({tag, ".quotient"}, 64'(quotient8), eq);
    chk({tag, ".remainder"}, 64'(remainder8), er);
    chk({tag, ".div_by_zero"}, 64'(div_by_zero8), 64'(ed));
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk({tag, ".post_in_ready"}, 64'(in_ready8), 64'd1);
  endtask

  task automatic abort_test(input string tag, input bit use_reset);
    int seen;
    start = 1'b1; sign = 1'b0; dividend = 32'd1000; divider = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; start = 1'b0; out_ready = 1'b0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".div_by_zero"}, 64'(div_by_zero), 64'd0);
    if (use_reset) chk({tag, ".cleared_qr"}, {32'(remainder), 32'(quotient)}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk({tag, ".no_result"}, 64'(seen), 64'd0);
    do_op32({tag, ".9div3"}, 1'b0, 32'd9, 32'd3, 0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 20));
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; sign = 1'b0; flush = 1'b0; out_ready = 1'b0;
    dividend = '0; divider = '0;
    start8 = 1'b0; sign8 = 1'b0; flush8 = 1'b0; out_ready8 = 1'b0;
    dividend8 = '0; divider8 = '0;
    repeat (2) @(negedge clk);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.div_by_zero", 64'(div_by_zero), 64'd0);
    chk("reset.qr", {32'(remainder), 32'(quotient)}, 64'd0);
    chk("reset.in_ready8", 64'(in_ready8), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    do_op32("u100div7", 1'b0, 32'd100, 32'd7, 0);
    chk("u100div7.q_lit", 64'(quotient), 64'd14);
    chk("u100div7.r_lit", 64'(remainder), 64'd2);
    do_op32("s-7div2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    chk("s-7div2.q_lit", 64'(quotient), 64'hFFFF_FFFD);
    chk("s-7div2.r_lit", 64'(remainder), 64'hFFFF_FFFF);
    do_op32("s7div-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    chk("s7div-2.q_lit", 64'(quotient), 64'hFFFF_FFFD);
    chk("s7div-2.r_lit", 64'(remainder), 64'd1);
    do_op32("s_minneg_div-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("s_minneg_div-1.q_lit", 64'(quotient), 64'h8000_0000);
    do_op32("u_minneg_divmax", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("u_minneg_divmax.r_lit", 64'(remainder), 64'h8000_0000);
    do_op32("u5div0", 1'b0, 32'd5, 32'd0, 2);
    do_op32("s5div0", 1'b1, 32'd5, 32'd0, 0);
    chk("s5div0.q_lit", 64'(quotient), 64'hFFFF_FFFF);
    do_op32("s_neg_div0", 1'b1, 32'hFFFF_FFF0, 32'd0, 0);
    do_op32("backpressure5", 1'b0, 32'd12345, 32'd17, 5);

    abort_test("flush", 1'b0);
    abort_test("reset", 1'b1);

    start = 1'b1; sign = 1'b0; dividend = 32'd5; divider = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("dz_flush.pre_valid", 64'(out_valid), 64'd1);
    chk("dz_flush.pre_dbz", 64'(div_by_zero), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("dz_flush.valid", 64'(out_valid), 64'd0);
    chk("dz_flush.dbz", 64'(div_by_zero), 64'd0);
    chk("dz_flush.in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 24; i++)
      do_op32("rand32", 1'($urandom), rnd_operand(), rnd_operand(), $urandom_range(0, 3));

    do_op8("w8_200div13", 1'b0, 8'd200, 8'd13);
    chk("w8_200div13.q_lit", 64'(quotient8), 64'd15);
    chk("w8_200div13.r_lit", 64'(remainder8), 64'd5);
    do_op8("w8_minneg", 1'b1, 8'h80, 8'hFF);
    do_op8("w8_div0", 1'b1, 8'h85, 8'h00);
    for (int i = 0; i < 12; i++)
      do_op8("rand8", 1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
